// File: rtl/vit_sched_pkg.sv
// Shared types and constants for the Viterbi frame scheduler.
package vit_sched_pkg;

  localparam int unsigned PKT_W    = 16;
  localparam int unsigned BYTE_W   = 8;
  // Tag channel field is sized for the largest supported channel count.
  localparam int unsigned TAG_CH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                flush;
    logic [TAG_CH_W-1:0] ch;
  } sched_tag_t;

  localparam logic [PKT_W-1:0] FLUSH_WORD = 16'h0000;

endpackage

// File: rtl/vit_tag_fifo.sv
// Synchronous FIFO of outstanding-packet tags; push and pop together are legal even when full.
module vit_tag_fifo
  import vit_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  sched_tag_t push_tag,
  input  logic       pop,
  output sched_tag_t pop_tag,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  sched_tag_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok_c;
  logic          pop_ok_c;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign pop_ok_c  = pop & ~empty;
  assign push_ok_c = push & (~full | pop_ok_c);
  assign pop_tag   = mem[rd_ptr_q];

  // Storage array carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q] <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_c, pop_ok_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vit_frame_scheduler.sv
// Round-robin frame scheduler sharing one Viterbi decode path between N_CH requesters.
// Appends flush packets after each frame and routes decoded bytes back by channel tag.
module vit_frame_scheduler
  import vit_sched_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned FLUSH_PKTS = 2,
  parameter int unsigned TAG_DEPTH  = 16,
  parameter int unsigned CH_W       = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req_valid_i,
  input  logic [N_CH*PKT_W-1:0] req_data_i,
  input  logic [N_CH-1:0]       req_last_i,
  output logic [N_CH-1:0]       req_ready_o,
  output logic                  dec_dvalid_o,
  output logic [PKT_W-1:0]      dec_data_o,
  input  logic                  dec_busy_i,
  input  logic                  dec_valid_i,
  input  logic [BYTE_W-1:0]     dec_data_i,
  output logic                  out_valid_o,
  output logic [BYTE_W-1:0]     out_data_o,
  output logic [CH_W-1:0]       out_ch_o,
  output logic                  err_o
);

  localparam int unsigned FC_W = $clog2(FLUSH_PKTS + 1);

  sched_state_e     state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             gap_q;

  logic             pick_found_c;
  logic [CH_W-1:0]  pick_ch_c;
  int unsigned      idx;
  logic [PKT_W-1:0] grant_data_c;
  logic             grant_valid_c;
  logic             grant_last_c;
  logic             can_issue_c;
  logic             issue_c;
  logic [PKT_W-1:0] issue_data_c;
  sched_tag_t       push_tag_c;

  sched_tag_t       tag_rd;
  logic             tag_full;
  logic             tag_empty;
  logic             pop_c;

  assign can_issue_c = ~dec_busy_i & ~tag_full & ~gap_q;
  assign pop_c       = dec_valid_i & ~tag_empty;

  // First valid requester at or after the round-robin pointer.
  always_comb begin : rr_pick
    pick_found_c = 1'b0;
    pick_ch_c    = rr_q;
    idx          = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(rr_q) + i) % N_CH;
      if (!pick_found_c && req_valid_i[CH_W'(idx)]) begin
        pick_found_c = 1'b1;
        pick_ch_c    = CH_W'(idx);
      end
    end
  end

  always_comb begin : grant_mux
    grant_data_c  = '0;
    grant_valid_c = 1'b0;
    grant_last_c  = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (grant_q == CH_W'(c)) begin
        grant_data_c  = req_data_i[c*PKT_W +: PKT_W];
        grant_valid_c = req_valid_i[c];
        grant_last_c  = req_last_i[c];
      end
    end
  end

  // Ready is a function of state and issue gating only, never of req_valid_i.
  always_comb begin : ready_gen
    req_ready_o = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      req_ready_o[c] = (state_q == DATA) && (grant_q == CH_W'(c)) && can_issue_c;
    end
  end

  always_comb begin : fsm_next
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    flush_cnt_d      = flush_cnt_q;
    issue_c          = 1'b0;
    issue_data_c     = FLUSH_WORD;
    push_tag_c.flush = 1'b0;
    push_tag_c.ch    = TAG_CH_W'(grant_q);
    case (state_q)
      IDLE: begin
        if (pick_found_c) begin
          grant_d = pick_ch_c;
          state_d = DATA;
        end
      end
      DATA: begin
        if (grant_valid_c && can_issue_c) begin
          issue_c      = 1'b1;
          issue_data_c = grant_data_c;
          if (grant_last_c) begin
            flush_cnt_d = '0;
            rr_d        = CH_W'((32'(grant_q) + 32'd1) % N_CH);
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (can_issue_c) begin
          issue_c          = 1'b1;
          push_tag_c.flush = 1'b1;
          if (flush_cnt_q == FC_W'(FLUSH_PKTS - 1)) begin
            state_d = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + FC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      flush_cnt_q  <= '0;
      gap_q        <= 1'b0;
      dec_dvalid_o <= 1'b0;
      dec_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      flush_cnt_q  <= flush_cnt_d;
      gap_q        <= issue_c;
      dec_dvalid_o <= issue_c;
      if (issue_c) begin
        dec_data_o <= issue_data_c;
      end
    end
  end

  // Return path: route data bytes by tag, drop flush bytes, flag orphan bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      out_valid_o <= pop_c & ~tag_rd.flush;
      if (pop_c && !tag_rd.flush) begin
        out_data_o <= dec_data_i;
        out_ch_o   <= CH_W'(tag_rd.ch);
      end
      if (dec_valid_i && tag_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  vit_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_c),
    .push_tag (push_tag_c),
    .pop      (pop_c),
    .pop_tag  (tag_rd),
    .full     (tag_full),
    .empty    (tag_empty)
  );

endmodule

// File: tb/tb_vit_frame_scheduler.sv
// Directed scoreboard bench for vit_frame_scheduler with a simple in-order decoder model.
module tb_vit_frame_scheduler;

  localparam int unsigned N_CH = 2;
  localparam int unsigned CH_W = 1;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   req_valid;
  logic [N_CH*16-1:0] req_data;
  logic [N_CH-1:0]   req_last;
  logic [N_CH-1:0]   req_ready_o;
  logic              dec_dvalid_o;
  logic [15:0]       dec_data_o;
  logic              dec_busy;
  logic              dec_valid_i;
  logic [7:0]        dec_data_i;
  logic              out_valid_o;
  logic [7:0]        out_data_o;
  logic [CH_W-1:0]   out_ch_o;
  logic              err_o;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] dq[$];
  int          dt[$];
  logic [8:0]  exp_q[$];
  int          acc_order[$];
  int          issue_cnt = 0;
  int          zero_cnt = 0;
  int          out_cnt = 0;
  int          last_issue = -100;
  int          lat = 20;
  bit          hold = 0;
  int          inject_req = 0;
  int          inject_done = 0;
  int          pop_req = 0;
  int          pop_done = 0;

  vit_frame_scheduler #(
    .N_CH       (N_CH),
    .FLUSH_PKTS (2),
    .TAG_DEPTH  (16),
    .CH_W       (CH_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready_o),
    .dec_dvalid_o (dec_dvalid_o),
    .dec_data_o   (dec_data_o),
    .dec_busy_i   (dec_busy),
    .dec_valid_i  (dec_valid_i),
    .dec_data_i   (dec_data_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ch_o     (out_ch_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decoder model and output scoreboard, evaluated at every falling edge.
  initial begin
    dec_valid_i = 1'b0;
    dec_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (dec_dvalid_o) begin
        issue_cnt++;
        if (dec_data_o == 16'h0000) zero_cnt++;
        check("issue_gap", 32'((cyc - last_issue) >= 2), 1);
        last_issue = cyc;
        dq.push_back(dec_data_o);
        dt.push_back(cyc + lat);
      end
      if (out_valid_o) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_data", out_data_o, e[7:0]);
          check("out_ch", out_ch_o, e[8]);
        end
      end
      if (!rst_n) begin
        dq.delete();
        dt.delete();
        dec_valid_i = 1'b0;
      end else if (inject_req != inject_done) begin
        dec_valid_i = 1'b1;
        dec_data_i  = 8'h77;
        inject_done++;
      end else if (dq.size() > 0 && (pop_req != pop_done || (!hold && dt[0] <= cyc))) begin
        logic [15:0] p;
        p = dq.pop_front();
        void'(dt.pop_front());
        dec_valid_i = 1'b1;
        dec_data_i  = p[7:0];
        if (pop_req != pop_done) pop_done++;
      end else begin
        dec_valid_i = 1'b0;
      end
    end
  end

  // Drive one packet; valid stays high afterwards unless it is the frame's last packet.
  task automatic send_pkt(input int ch, input logic [7:0] b, input logic last);
    bit acc;
    acc = 1'b0;
    if (!req_valid[ch]) @(negedge clk);
    req_valid[ch]          = 1'b1;
    req_data[ch*16 +: 16] = {~b, b};
    req_last[ch]           = last;
    for (int i = 0; i < 400 && !acc; i++) begin
      #1;
      acc = req_ready_o[ch];
      @(negedge clk);
    end
    if (last) begin
      req_valid[ch] = 1'b0;
      req_last[ch]  = 1'b0;
    end
    check("accept", 32'(acc), 1);
    if (acc) begin
      exp_q.push_back({ch[0], b});
      acc_order.push_back(ch);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("drain_done", 32'(n < 2000), 1);
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_dvalid"}, dec_dvalid_o, 0);
    check({t, "_ddata"},  dec_data_o, 0);
    check({t, "_ovalid"}, out_valid_o, 0);
    check({t, "_odata"},  out_data_o, 0);
    check({t, "_och"},    out_ch_o, 0);
    check({t, "_err"},    err_o, 0);
    check({t, "_ready"},  req_ready_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    acc_order.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic two_ch_frames(input int frames);
    acc_order.delete();
    fork
      begin
        for (int f = 0; f < frames; f++) send_pkt(0, 8'(8'h11 + 8'(f)), 1'b1);
      end
      begin
        for (int f = 0; f < frames; f++) send_pkt(1, 8'(8'h31 + 8'(f)), 1'b1);
      end
    join
    drain();
  endtask

  initial begin
    int i0, z0, o0, n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    dec_busy  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two-packet frame on ch0: two data issues, two flush issues, two routed bytes.
    lat = 20; i0 = issue_cnt; z0 = zero_cnt; o0 = out_cnt;
    send_pkt(0, 8'hA5, 1'b0);
    send_pkt(0, 8'h3C, 1'b1);
    drain();
    check("t1_issues", 32'(issue_cnt - i0), 4);
    check("t1_flush_issues", 32'(zero_cnt - z0), 2);
    check("t1_outputs", 32'(out_cnt - o0), 2);

    // Round-robin from reset with both channels requesting.
    @(negedge clk);
    do_reset();
    lat = 3;
    two_ch_frames(2);
    check("rr_count", 32'(acc_order.size()), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < acc_order.size()) check($sformatf("rr_grant%0d", k), 32'(acc_order[k]), 32'(k % 2));
    end

    // Decoder busy for 50 cycles while a frame is granted.
    i0 = issue_cnt; z0 = zero_cnt;
    @(negedge clk);
    dec_busy = 1'b1;
    fork
      send_pkt(0, 8'h5E, 1'b1);
      begin
        repeat (50) @(negedge clk);
        #1;
        check("busy_no_issue", 32'(issue_cnt - i0), 0);
        check("busy_ready", req_ready_o, 0);
        @(negedge clk);
        dec_busy = 1'b0;
      end
    join
    drain();
    check("busy_issues", 32'(issue_cnt - i0), 3);
    check("busy_flush_issues", 32'(zero_cnt - z0), 2);

    // Decoder withholds bytes until the tag FIFO fills.
    hold = 1'b1; i0 = issue_cnt;
    for (int k = 0; k < 16; k++) send_pkt(0, 8'(8'h80 + k), 1'b0);
    req_data[15:0] = 16'h38C7;
    req_last[0]    = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("full_issues", 32'(issue_cnt - i0), 16);
    check("full_ready", req_ready_o[0], 0);
    pop_req++;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!dec_valid_i && n < 20);
    check("single_pop", dec_valid_i, 1);
    @(negedge clk);
    #1;
    check("ready_after_pop", req_ready_o[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    exp_q.push_back({1'b0, 8'hC7});
    hold = 1'b0;
    drain();

    // Orphan byte with no outstanding tag.
    o0 = out_cnt;
    inject_req++;
    repeat (3) @(negedge clk);
    #1;
    check("err_set", err_o, 1);
    repeat (5) @(negedge clk);
    #1;
    check("err_sticky", err_o, 1);
    check("err_no_out", 32'(out_cnt - o0), 0);

    // Back-to-back packets on ch1 with a fast decoder.
    lat = 2; i0 = issue_cnt;
    @(negedge clk);
    send_pkt(1, 8'h61, 1'b0);
    send_pkt(1, 8'h62, 1'b0);
    send_pkt(1, 8'h63, 1'b0);
    send_pkt(1, 8'h64, 1'b1);
    drain();
    check("b2b_issues", 32'(issue_cnt - i0), 6);

    // Reset while in FLUSH, then check the next grant restarts at ch0.
    send_pkt(0, 8'h9A, 1'b1);
    do_reset();
    #1;
    check_reset_outputs("flush_rst");
    two_ch_frames(1);
    check("post_rst_count", 32'(acc_order.size()), 2);
    if (acc_order.size() > 0) check("post_rst_first", 32'(acc_order[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vit_frame_scheduler.md
# vit_frame_scheduler

Frame-level scheduler that shares one Viterbi decode path (FIFO → PISO → Viterbi core → SIPO, 16-bit symbol packets in, 8-bit bytes out) between `N_CH` requesters. It grants the decoder to one channel per frame using round-robin arbitration. After every frame it inserts `FLUSH_PKTS` all-zero packets so the traceback drains. Each returned byte is routed back with its channel ID; flush-derived bytes are discarded.

## Interface
- `N_CH`, default 2: number of requesting channels.
- `FLUSH_PKTS`, default 2: zero packets appended per frame (2 × 8 bits covers TBL=15).
- `TAG_DEPTH`, default 16: outstanding-packet tag FIFO depth, power of two.
- `CH_W`, default $clog2(N_CH): channel ID width.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid_i`, input, N_CH: per-channel packet valid.
- `req_data_i`, input, N_CH*16: per-channel encoded packet; channel c occupies bits [16c+15:16c].
- `req_last_i`, input, N_CH: marks the final packet of a frame.
- `req_ready_o`, output, N_CH: packet accepted when `valid & ready` at a clock edge.
- `dec_dvalid_o`, output, 1: one-cycle packet strobe to the decoder.
- `dec_data_o`, output, 16: packet to the decoder.
- `dec_busy_i`, input, 1: decoder cannot accept a packet.
- `dec_valid_i`, input, 1: decoded byte strobe.
- `dec_data_i`, input, 8: decoded byte.
- `out_valid_o`, output, 1: routed byte strobe.
- `out_data_o`, output, 8: routed byte.
- `out_ch_o`, output, CH_W: channel owning the routed byte.
- `err_o`, output, 1: sticky flag; set when `dec_valid_i` arrives with the tag FIFO empty.

## Operation
- FSM states: IDLE, DATA, FLUSH.
- IDLE: grant the first channel with `req_valid_i` high, searching from round-robin pointer `rr`; go to DATA. Stay in IDLE if no channel is valid.
- DATA: `req_ready_o[g] = can_issue`. All other ready bits are 0.
  - `can_issue = !dec_busy_i & !tag_full & !gap`.
  - On accept, register the packet to `dec_data_o` and pulse `dec_dvalid_o`.
  - Push tag {flush=0, ch=g}.
  - If `req_last_i[g]` is set: clear the flush counter, set `rr = g+1` (mod N_CH), go to FLUSH.
- FLUSH: on each `can_issue` cycle, issue 16'h0000 and push tag {flush=1, ch=g}. After FLUSH_PKTS issues, go to IDLE.
- `gap`: set for the cycle after any issue. This forces issue spacing of at least 2 cycles, so a packet is never sent before the decoder can raise `dec_busy_i`.
- Tag FIFO: pop on `dec_valid_i`.
  - If the popped tag has flush=0: register `out_valid_o=1`, `out_data_o=dec_data_i`, `out_ch_o=tag.ch`.
  - If the popped tag has flush=1: drop the byte.
  - If the FIFO is empty: set `err_o`, produce no output, leave the pointers unchanged.
  - Simultaneous push and pop is legal at any occupancy, including full (pop frees the slot, push succeeds).
- Decoder byte order equals packet order. No reordering logic is needed.

## Timing
- Reset values: all outputs 0, `rr`=0, state IDLE, tag FIFO empty, `gap`=0, `err_o`=0.
- Grant latency: `req_valid_i` rising in IDLE gives `req_ready_o` high in the next cycle at the earliest.
- Issue latency: an accept at edge N gives `dec_dvalid_o`/`dec_data_o` valid during cycle N+1, for exactly one cycle.
- `dec_data_o` holds its last value when `dec_dvalid_o` is low.
- Return latency: `dec_valid_i` at edge M gives `out_valid_o` during cycle M+1, for one cycle.
- `req_ready_o` depends only on state, `dec_busy_i`, `tag_full`, and `gap`. It never depends on `req_valid_i`.
- `dec_busy_i` high stalls DATA and FLUSH indefinitely with no loss or duplication.
- Reset mid-frame aborts the frame and empties the tags. Bytes still inside the decoder are the system reset's responsibility.

## Structure
- `vit_sched_pkg`:
  - `sched_state_e` {IDLE, DATA, FLUSH}.
  - `sched_tag_t` {logic flush; logic [CH_W-1:0] ch}.
  - `FLUSH_WORD` = 16'h0000.
- Sub-module `vit_tag_fifo`: synchronous FIFO of `sched_tag_t`, depth TAG_DEPTH, with full/empty flags.
- The FSM, arbiter and output register live in the top level.

## Test plan
- Ch0 sends frame {A5, 3C} (encoded, last on 3C), FLUSH_PKTS=2, decoder model returns bytes in order after 20 cycles → four `dec_dvalid_o` pulses (two data, two 0000); output is A5 then 3C on ch 0; flush bytes produce no `out_valid_o`.
- Ch0 and ch1 both request from reset with 1-packet frames, repeated twice → grant order 0, 1, 0, 1; `out_ch_o` sequence 0, 1, 0, 1.
- `dec_busy_i` forced high for 50 cycles in DATA → no `dec_dvalid_o`, `req_ready_o`=0; after release, the packet issues once.
- Decoder withholds output → after 16 issues `req_ready_o` drops; one `dec_valid_i` pop → ready returns the next cycle.
- `dec_valid_i` pulsed with the tag FIFO empty → `err_o`=1 and it stays 1; `out_valid_o` remains 0.
- Back-to-back `req_valid_i` with the decoder never busy → `dec_dvalid_o` pulses at least 2 cycles apart; `rst_n` low during FLUSH → all outputs 0 and the next grant goes to ch0.
